bram_port_arbiter: RTL and testbench

//  Two-requester arbiter sharing the single BRAM port of the AXI BRAM peripheral.

---
 rtl/bram_port_arbiter_if.sv | 53 +++++
 rtl/bram_port_arbiter.sv | 118 +++++++++++
 tb/tb_bram_port_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_port_arbiter_if.sv
// Request, response and BRAM-side signals shared by the two requesters and the arbiter.
interface bram_port_arbiter_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  a_req_valid;
    logic                  a_req_ready;
    logic                  a_req_we;
    logic [ADDR_WIDTH-1:0] a_req_addr;
    logic [DATA_WIDTH-1:0] a_req_wdata;
    logic [STRB_WIDTH-1:0] a_req_wstrb;
    logic                  a_rsp_valid;
    logic                  a_rsp_we;
    logic [DATA_WIDTH-1:0] a_rsp_rdata;

    logic                  b_req_valid;
    logic                  b_req_ready;
    logic                  b_req_we;
    logic [ADDR_WIDTH-1:0] b_req_addr;
    logic [DATA_WIDTH-1:0] b_req_wdata;
    logic [STRB_WIDTH-1:0] b_req_wstrb;
    logic                  b_rsp_valid;
    logic                  b_rsp_we;
    logic [DATA_WIDTH-1:0] b_rsp_rdata;

    logic                  bram_en;
    logic [STRB_WIDTH-1:0] bram_we;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [DATA_WIDTH-1:0] bram_wdata;
    logic [DATA_WIDTH-1:0] bram_rdata;

    // Arbiter side
    modport slave (
        input  a_req_valid, a_req_we, a_req_addr, a_req_wdata, a_req_wstrb,
        output a_req_ready, a_rsp_valid, a_rsp_we, a_rsp_rdata,
        input  b_req_valid, b_req_we, b_req_addr, b_req_wdata, b_req_wstrb,
        output b_req_ready, b_rsp_valid, b_rsp_we, b_rsp_rdata,
        output bram_en, bram_we, bram_addr, bram_wdata,
        input  bram_rdata
    );

    // Requester / BRAM environment side
    modport master (
        output a_req_valid, a_req_we, a_req_addr, a_req_wdata, a_req_wstrb,
        input  a_req_ready, a_rsp_valid, a_rsp_we, a_rsp_rdata,
        output b_req_valid, b_req_we, b_req_addr, b_req_wdata, b_req_wstrb,
        input  b_req_ready, b_rsp_valid, b_rsp_we, b_rsp_rdata,
        input  bram_en, bram_we, bram_addr, bram_wdata,
        output bram_rdata
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter with bounded bursts sharing one BRAM port between
// requesters A and B, returning responses after a fixed read latency.
module bram_port_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int MAX_BURST  = 4
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    bram_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
    typedef enum logic {PORT_A, PORT_B} port_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);
    localparam int         TAIL    = RD_LATENCY - 1;

    state_t state_q, state_d;
    logic [3:0] burst_q, burst_d;
    port_t rr_last_q, rr_last_d;
    logic grant_a, grant_b, grant;

    logic [RD_LATENCY-1:0] pipe_vld, pipe_port, pipe_we;
    logic tail_a, tail_b;

    // State, burst counter and round-robin pointer registers
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= IDLE;
            burst_q   <= '0;
            rr_last_q <= PORT_B;
        end else begin
            state_q   <= state_d;
            burst_q   <= burst_d;
            rr_last_q <= rr_last_d;
        end
    end

    // Grant selection and next-state computation
    always_comb begin
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        state_d   = state_q;
        burst_d   = burst_q;
        rr_last_d = rr_last_q;
        unique case (state_q)
            IDLE: begin
                if (bus.a_req_valid && bus.b_req_valid) begin
                    grant_a = (rr_last_q == PORT_B);
                    grant_b = (rr_last_q == PORT_A);
                end else begin
                    grant_a = bus.a_req_valid;
                    grant_b = bus.b_req_valid;
                end
            end
            OWN_A: begin
                if (bus.a_req_valid && (!bus.b_req_valid || burst_q != MAX_CNT))
                    grant_a = 1'b1;
                else
                    grant_b = bus.b_req_valid;
            end
            OWN_B: begin
                if (bus.b_req_valid && (!bus.a_req_valid || burst_q != MAX_CNT))
                    grant_b = 1'b1;
                else
                    grant_a = bus.a_req_valid;
            end
            default: ;
        endcase
        // Owner keeps counting (saturating); a new owner restarts at 1.
        if (grant_a) begin
            state_d   = OWN_A;
            rr_last_d = PORT_A;
            if (state_q != OWN_A)        burst_d = 4'd1;
            else if (burst_q != MAX_CNT) burst_d = burst_q + 4'd1;
        end else if (grant_b) begin
            state_d   = OWN_B;
            rr_last_d = PORT_B;
            if (state_q != OWN_B)        burst_d = 4'd1;
            else if (burst_q != MAX_CNT) burst_d = burst_q + 4'd1;
        end else begin
            state_d = IDLE;
        end
    end

    assign grant           = grant_a | grant_b;
    assign bus.a_req_ready = grant_a;
    assign bus.b_req_ready = grant_b;
    assign bus.bram_en     = grant;
    assign bus.bram_addr   = grant_a ? bus.a_req_addr  : grant_b ? bus.b_req_addr  : '0;
    assign bus.bram_wdata  = grant_a ? bus.a_req_wdata : grant_b ? bus.b_req_wdata : '0;
    assign bus.bram_we     = (grant_a && bus.a_req_we) ? bus.a_req_wstrb :
                             (grant_b && bus.b_req_we) ? bus.b_req_wstrb : '0;

    // Response tag pipeline; stage 0 is the LSB, the tail is the MSB
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            pipe_vld  <= '0;
            pipe_port <= '0;
            pipe_we   <= '0;
        end else begin
            pipe_vld  <= RD_LATENCY'({pipe_vld, grant});
            pipe_port <= RD_LATENCY'({pipe_port, grant_b});
            pipe_we   <= RD_LATENCY'({pipe_we, grant_b ? bus.b_req_we : (grant_a & bus.a_req_we)});
        end
    end

    assign tail_a = pipe_vld[TAIL] && !pipe_port[TAIL];
    assign tail_b = pipe_vld[TAIL] &&  pipe_port[TAIL];

    assign bus.a_rsp_valid = tail_a;
    assign bus.a_rsp_we    = tail_a && pipe_we[TAIL];
    assign bus.a_rsp_rdata = (tail_a && !pipe_we[TAIL]) ? bus.bram_rdata : '0;
    assign bus.b_rsp_valid = tail_b;
    assign bus.b_rsp_we    = tail_b && pipe_we[TAIL];
    assign bus.b_rsp_rdata = (tail_b && !pipe_we[TAIL]) ? bus.bram_rdata : '0;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: two instances (read latency 1 and 2) share one
// request stream; a scoreboard per instance checks every response.
module tb_bram_port_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam bit PA = 1'b0;
    localparam bit PB = 1'b1;
    localparam byte GA = 8'h41;  // 'A'
    localparam byte GB = 8'h42;  // 'B'
    localparam byte GN = 8'h2d;  // '-'

    typedef struct { logic port; logic we; logic [31:0] data; int due; } exp_t;
    typedef struct { logic we; logic [9:0] addr; logic [31:0] wdata; logic [3:0] strb; } req_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic a_valid = 1'b0, a_we = 1'b0, b_valid = 1'b0, b_we = 1'b0;
    logic [9:0] a_addr = '0, b_addr = '0;
    logic [31:0] a_wdata = '0, b_wdata = '0;
    logic [3:0] a_wstrb = '0, b_wstrb = '0;

    bram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if0 ();
    bram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();

    bram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .MAX_BURST(4))
        dut0 (.ACLK(clk), .ARESETN(rst_n), .bus(if0.slave));
    bram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2), .MAX_BURST(4))
        dut1 (.ACLK(clk), .ARESETN(rst_n), .bus(if1.slave));

    assign if0.a_req_valid = a_valid;  assign if1.a_req_valid = a_valid;
    assign if0.a_req_we    = a_we;     assign if1.a_req_we    = a_we;
    assign if0.a_req_addr  = a_addr;   assign if1.a_req_addr  = a_addr;
    assign if0.a_req_wdata = a_wdata;  assign if1.a_req_wdata = a_wdata;
    assign if0.a_req_wstrb = a_wstrb;  assign if1.a_req_wstrb = a_wstrb;
    assign if0.b_req_valid = b_valid;  assign if1.b_req_valid = b_valid;
    assign if0.b_req_we    = b_we;     assign if1.b_req_we    = b_we;
    assign if0.b_req_addr  = b_addr;   assign if1.b_req_addr  = b_addr;
    assign if0.b_req_wdata = b_wdata;  assign if1.b_req_wdata = b_wdata;
    assign if0.b_req_wstrb = b_wstrb;  assign if1.b_req_wstrb = b_wstrb;

    logic [1:0] a_rdy, b_rdy, a_rv, b_rv, a_rwe, b_rwe, en;
    logic [1:0][31:0] a_rd, b_rd, wdat;
    logic [1:0][9:0] addr;
    logic [1:0][3:0] bwe;
    assign a_rdy = {if1.a_req_ready, if0.a_req_ready};
    assign b_rdy = {if1.b_req_ready, if0.b_req_ready};
    assign a_rv  = {if1.a_rsp_valid, if0.a_rsp_valid};
    assign b_rv  = {if1.b_rsp_valid, if0.b_rsp_valid};
    assign a_rwe = {if1.a_rsp_we, if0.a_rsp_we};
    assign b_rwe = {if1.b_rsp_we, if0.b_rsp_we};
    assign a_rd  = {if1.a_rsp_rdata, if0.a_rsp_rdata};
    assign b_rd  = {if1.b_rsp_rdata, if0.b_rsp_rdata};
    assign en    = {if1.bram_en, if0.bram_en};
    assign bwe   = {if1.bram_we, if0.bram_we};
    assign addr  = {if1.bram_addr, if0.bram_addr};
    assign wdat  = {if1.bram_wdata, if0.bram_wdata};

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] m;
        m = '0;
        for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{strb[k[1:0]]}};
        return (old & ~m) | (nw & m);
    endfunction

    // BRAM models: latency 1 for dut0, latency 2 for dut1
    logic [31:0] mem0 [1024] = '{default: '0};
    logic [31:0] mem1 [1024] = '{default: '0};
    logic [31:0] r0 = '0, r1a = '0, r1b = '0;
    always @(posedge clk) begin
        if (if0.bram_en) begin
            r0 <= mem0[if0.bram_addr];
            mem0[if0.bram_addr] <= merge(mem0[if0.bram_addr], if0.bram_wdata, if0.bram_we);
        end
        if (if1.bram_en) begin
            r1a <= mem1[if1.bram_addr];
            mem1[if1.bram_addr] <= merge(mem1[if1.bram_addr], if1.bram_wdata, if1.bram_we);
        end
        r1b <= r1a;
    end
    assign if0.bram_rdata = r0;
    assign if1.bram_rdata = r1b;

    logic [31:0] ref_mem [1024] = '{default: '0};
    exp_t sb0[$], sb1[$];
    req_t qa[$], qb[$];
    byte glog[$];
    int lat[2] = '{1, 2};
    logic [31:0] last_rdata[2];
    int cyc = 0;
    int ncmp = 0;
    int nfail = 0;
    string ctx = "init";

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL [%s] %s: observed %0h expected %0h", ctx, tag, obs, exp);
        end
    endtask

    function automatic int sb_size(input bit d);
        return d ? sb1.size() : sb0.size();
    endfunction
    function automatic int sb_due(input bit d);
        return d ? sb1[0].due : sb0[0].due;
    endfunction
    function automatic exp_t sb_pop(input bit d);
        return d ? sb1.pop_front() : sb0.pop_front();
    endfunction
    function automatic void sb_push(input bit d, input exp_t e);
        if (d) sb1.push_back(e); else sb0.push_back(e);
    endfunction

    task automatic rd(input bit p, input int a);
        req_t r;
        r = '{1'b0, 10'(a), 32'h0, 4'h0};
        if (p) qb.push_back(r); else qa.push_back(r);
    endtask
    task automatic wr(input bit p, input int a, input logic [31:0] d, input logic [3:0] s);
        req_t r;
        r = '{1'b1, 10'(a), d, s};
        if (p) qb.push_back(r); else qa.push_back(r);
    endtask

    task automatic load_a();
        req_t r;
        if (qa.size() != 0) begin
            r = qa.pop_front();
            a_valid = 1'b1; a_we = r.we; a_addr = r.addr; a_wdata = r.wdata; a_wstrb = r.strb;
        end else a_valid = 1'b0;
    endtask
    task automatic load_b();
        req_t r;
        if (qb.size() != 0) begin
            r = qb.pop_front();
            b_valid = 1'b1; b_we = r.we; b_addr = r.addr; b_wdata = r.wdata; b_wstrb = r.strb;
        end else b_valid = 1'b0;
    endtask
    task automatic kick();
        if (!a_valid) load_a();
        if (!b_valid) load_b();
    endtask

    // Check responses of one instance and record its newly accepted requests
    task automatic check_dut(input bit d);
        exp_t e;
        logic [31:0] rdat;
        chk("dual_ready", 64'(a_rdy[d] & b_rdy[d]), 64'(0));
        if (a_rv[d] || b_rv[d]) begin
            chk("dual_rsp", 64'(a_rv[d] & b_rv[d]), 64'(0));
            if (sb_size(d) == 0) chk("unexpected_rsp", 64'(a_rv[d] | b_rv[d]), 64'(0));
            else begin
                e = sb_pop(d);
                rdat = b_rv[d] ? b_rd[d] : a_rd[d];
                chk("rsp_port", 64'(b_rv[d]), 64'(e.port));
                chk("rsp_we", 64'(b_rv[d] ? b_rwe[d] : a_rwe[d]), 64'(e.we));
                chk("rsp_rdata", 64'(rdat), 64'(e.data));
                chk("rsp_cycle", 64'(cyc), 64'(e.due));
                if (!e.we) last_rdata[d] = rdat;
            end
        end else if (sb_size(d) != 0 && sb_due(d) <= cyc) begin
            chk("missing_rsp", 64'(a_rv[d] | b_rv[d]), 64'(1));
            void'(sb_pop(d));
        end
        if (a_valid && a_rdy[d]) sb_push(d, '{PA, a_we, a_we ? 32'h0 : ref_mem[a_addr], cyc + lat[d]});
        if (b_valid && b_rdy[d]) sb_push(d, '{PB, b_we, b_we ? 32'h0 : ref_mem[b_addr], cyc + lat[d]});
    endtask

    task automatic step();
        logic ha, hb;
        @(negedge clk);
        ha = a_valid & a_rdy[0];
        hb = b_valid & b_rdy[0];
        check_dut(1'b0);
        check_dut(1'b1);
        glog.push_back(ha ? GA : hb ? GB : GN);
        if (ha && a_we) ref_mem[a_addr] = merge(ref_mem[a_addr], a_wdata, a_wstrb);
        if (hb && b_we) ref_mem[b_addr] = merge(ref_mem[b_addr], b_wdata, b_wstrb);
        @(posedge clk);
        #1;
        cyc++;
        if (ha || !a_valid) load_a();
        if (hb || !b_valid) load_b();
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((qa.size() + qb.size() + sb0.size() + sb1.size() + int'(a_valid) + int'(b_valid)) != 0
               && n < limit) begin
            step();
            n++;
        end
        chk("drain_done", 64'(qa.size() + qb.size() + sb0.size() + sb1.size()
                              + int'(a_valid) + int'(b_valid)), 64'(0));
    endtask

    task automatic chk_rst(input bit d);
        chk("rst_ctrl", 64'({a_rdy[d], b_rdy[d], a_rv[d], b_rv[d], a_rwe[d], b_rwe[d], en[d]}), 64'(0));
        chk("rst_we", 64'(bwe[d]), 64'(0));
        chk("rst_addr", 64'(addr[d]), 64'(0));
        chk("rst_wdata", 64'(wdat[d]), 64'(0));
        chk("rst_a_rdata", 64'(a_rd[d]), 64'(0));
        chk("rst_b_rdata", 64'(b_rd[d]), 64'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb0.delete();
        sb1.delete();
        @(negedge clk);
        chk_rst(1'b0);
        chk_rst(1'b1);
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        string pat;
        rst_n = 1'b1;
        #2;
        ctx = "reset";
        do_reset();

        // Writes 1..4 to addr 0..3 then read them back from port A
        ctx = "t1_write_read";
        for (int i = 0; i < 4; i++) wr(PA, i, 32'(i + 1), 4'hF);
        for (int i = 0; i < 4; i++) rd(PA, i);
        kick();
        drain(50);
        chk("t1_last_rdata0", 64'(last_rdata[0]), 64'h4);
        chk("t1_last_rdata1", 64'(last_rdata[1]), 64'h4);

        // Continuous contention from reset: bursts of four
        ctx = "t2_burst";
        do_reset();
        glog.delete();
        for (int i = 0; i < 12; i++) begin
            rd(PA, i % 4);
            rd(PB, (i + 1) % 4);
        end
        kick();
        drain(100);
        pat = "AAAABBBBAAAABBBB";
        for (int i = 0; i < 16; i++) chk("t2_grant", 64'(glog[i]), 64'(pat[i]));

        // Byte-strobed partial write from B, read back from A
        ctx = "t3_strobe";
        wr(PA, 5, 32'hFFFF_FFFF, 4'hF);
        kick();
        drain(20);
        wr(PB, 5, 32'hDEAD_BEEF, 4'b0011);
        kick();
        drain(20);
        rd(PA, 5);
        kick();
        drain(20);
        chk("t3_rdata0", 64'(last_rdata[0]), 64'hFFFF_BEEF);
        chk("t3_rdata1", 64'(last_rdata[1]), 64'hFFFF_BEEF);

        // A alone saturates its burst count; B wins as soon as it asks
        ctx = "t4_saturate";
        for (int i = 0; i < 14; i++) rd(PA, i % 8);
        kick();
        glog.delete();
        repeat (10) step();
        for (int i = 0; i < 10; i++) chk("t4_a_alone", 64'(glog[i]), 64'(GA));
        rd(PB, 1);
        rd(PB, 2);
        kick();
        drain(60);
        chk("t4_b_first", 64'(glog[10]), 64'(GB));
        chk("t4_b_second", 64'(glog[11]), 64'(GB));
        chk("t4_back_to_a", 64'(glog[12]), 64'(GA));

        // Reset with reads in flight; last grant was A so only reset lets A win
        ctx = "t5_reset";
        rd(PA, 0);
        rd(PA, 1);
        kick();
        step();
        step();
        do_reset();
        repeat (3) step();
        glog.delete();
        rd(PA, 2);
        rd(PB, 3);
        kick();
        step();
        chk("t5_first_grant", 64'(glog[0]), 64'(GA));
        drain(20);

        // Alternating single requests from A and B
        ctx = "t6_alternate";
        glog.delete();
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) rd(PA, i % 4); else rd(PB, (i + 2) % 6);
            kick();
            step();
        end
        drain(20);
        for (int i = 0; i < 8; i++) chk("t6_grant", 64'(glog[i]), 64'((i % 2 == 0) ? GA : GB));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
